// File: rtl/uart_pkg.sv
// Shared definitions for the UART arbiter slice: default geometry,
// derived widths and the arbiter state encoding.
package uart_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_FIFO_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_MAX_BURST  = 4;

    // Occupancy needs one extra bit so a completely full FIFO is representable.
    localparam int COUNT_W  = $clog2(DEF_FIFO_DEPTH) + 1;
    localparam int REQ_ID_W = $clog2(DEF_NUM_REQ);

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake and FIFO write-side bundle for the TX arbiter.
// slave  : arbiter side (consumes requests, drives the FIFO write port)
// master : requesters plus the FIFO occupancy source
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [CNT_W-1:0]              fifo_data_count;
    logic                          fifo_wr_en;
    logic [FIFO_WIDTH-1:0]         fifo_data;

    modport master (
        output req_valid, req_last, req_data, fifo_data_count,
        input  req_ready, fifo_wr_en, fifo_data
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_data_count,
        output req_ready, fifo_wr_en, fifo_data
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin pick: first asserted request searching upward from the
// slot after last_id_i, wrapping modulo NUM_REQ. Purely combinational so
// the RX-side arbiter can reuse it unchanged.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] last_id_i,
    output logic [$clog2(NUM_REQ)-1:0] winner_o,
    output logic                       any_req_o
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic found;
    int   idx;

    // Scan every slot once, starting one past the previous owner so the
    // previous owner is considered last.
    always_comb begin
        winner_o = last_id_i;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_id_i) + k) % NUM_REQ;
            if (!found && req_i[idx]) begin
                winner_o = ID_W'(idx);
                found    = 1'b1;
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX FIFO among NUM_REQ byte-stream
// requesters. A grant lasts until req_last or MAX_BURST beats; writes reach
// the FIFO through registered strobe/data one cycle after acceptance.
// Optional build macro UART_ARB_STATS_EN adds beat_cnt_o / stall_cnt_o.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                       clk,
    input  logic                       reset_n,
    uart_tx_arbiter_if.slave           bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       busy_o
`ifdef UART_ARB_STATS_EN
    ,
    output logic [15:0]                beat_cnt_o,
    output logic [15:0]                stall_cnt_o
`endif
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] BURST_END = 8'(MAX_BURST - 1);

    arb_state_e            state_q;
    logic [ID_W-1:0]       grant_id_q;
    logic [7:0]            burst_cnt_q;
    logic                  fifo_wr_en_q;
    logic [FIFO_WIDTH-1:0] fifo_data_q;

    logic [ID_W-1:0]       winner;
    logic                  any_req;
    logic [CNT_W:0]        occ_inflight;
    logic                  space;
    logic                  gnt_valid;
    logic                  gnt_last;
    logic [FIFO_WIDTH-1:0] gnt_data;
    logic                  accept;
    logic [NUM_REQ-1:0]    ready_vec;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i     (bus.req_valid),
        .last_id_i (grant_id_q),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    // Room check counts the registered write still in flight, so the FIFO
    // can never be pushed past FIFO_DEPTH.
    always_comb begin
        occ_inflight = {1'b0, bus.fifo_data_count} + (CNT_W + 1)'(fifo_wr_en_q);
        space        = occ_inflight < (CNT_W + 1)'(FIFO_DEPTH);
        gnt_valid    = bus.req_valid[grant_id_q];
        gnt_last     = bus.req_last[grant_id_q];
        gnt_data     = bus.req_data[int'(grant_id_q) * FIFO_WIDTH +: FIFO_WIDTH];
        accept       = (state_q == ARB_GRANT) && gnt_valid && space;
        ready_vec    = '0;
        ready_vec[grant_id_q] = accept;
    end

    // Arbitration FSM with registered FIFO write port; reset wins over all.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ARB_IDLE;
            grant_id_q   <= ID_W'(NUM_REQ - 1);
            burst_cnt_q  <= '0;
            fifo_wr_en_q <= 1'b0;
            fifo_data_q  <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    fifo_wr_en_q <= 1'b0;
                    if (any_req) begin
                        grant_id_q  <= winner;
                        burst_cnt_q <= '0;
                        state_q     <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    fifo_wr_en_q <= accept;
                    if (accept) begin
                        fifo_data_q <= gnt_data;
                        burst_cnt_q <= burst_cnt_q + 8'd1;
                        if (gnt_last || burst_cnt_q == BURST_END) begin
                            state_q <= ARB_IDLE;
                        end
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = ready_vec;
    assign bus.fifo_wr_en = fifo_wr_en_q;
    assign bus.fifo_data  = fifo_data_q;
    assign grant_id_o     = grant_id_q;
    assign busy_o         = (state_q == ARB_GRANT);

`ifdef UART_ARB_STATS_EN
    logic [15:0] beat_cnt_q;
    logic [15:0] stall_cnt_q;
    logic        stall;

    assign stall = (state_q == ARB_GRANT) && gnt_valid && !space;

    // Beat counter wraps; stall counter sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (fifo_wr_en_q) begin
                beat_cnt_q <= beat_cnt_q + 16'd1;
            end
            if (stall && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign beat_cnt_o  = beat_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios followed by
// random traffic, checked cycle by cycle against a behavioural model and a
// per-requester in-order delivery scoreboard.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int MAXB  = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N), .FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH)) bus ();

    logic [1:0] grant_id;
    logic       busy;
`ifdef UART_ARB_STATS_EN
    logic [15:0] beat_cnt;
    logic [15:0] stall_cnt;
`endif

    uart_tx_arbiter #(
        .NUM_REQ(N), .FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH), .MAX_BURST(MAXB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .grant_id_o (grant_id),
        .busy_o     (busy)
`ifdef UART_ARB_STATS_EN
        ,
        .beat_cnt_o (beat_cnt),
        .stall_cnt_o(stall_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    // requester message queues (what each requester still has to send)
    logic [7:0] q_data [N][$];
    logic       q_last [N][$];
    // bytes each requester expects to see written to the FIFO, in order
    logic [7:0] exp_q  [N][$];
    int         seq    [N];
    bit         pause  [N];
    bit         drain;
    int         occ;

    // behavioural reference: owner -1 means nobody holds the FIFO
    int         m_owner;
    int         m_last;
    int         m_beats;
    bit         m_wr;
    logic [7:0] m_data;
    int         m_beat_cnt;
    int         m_stall_cnt;

    int glog[$];
    int exp_rot[5] = '{0, 1, 2, 3, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] pred_ready();
        logic [N-1:0] r;
        r = '0;
        if (m_owner >= 0 && bus.req_valid[m_owner] === 1'b1 && (occ + int'(m_wr)) < DEPTH)
            r[m_owner] = 1'b1;
        return r;
    endfunction

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]       = !pause[i] && q_data[i].size() > 0;
            bus.req_last[i]        = (q_data[i].size() > 0) ? q_last[i][0] : 1'b0;
            bus.req_data[i*W +: W] = (q_data[i].size() > 0) ? q_data[i][0] : 8'h00;
        end
        bus.fifo_data_count = 5'(occ);
    endtask

    task automatic add_beat(input int src, input logic [7:0] d, input bit last);
        q_data[src].push_back(d);
        q_last[src].push_back(last);
        exp_q[src].push_back(d);
    endtask

    task automatic add_msg(input int src, input int len);
        for (int k = 0; k < len; k++) begin
            add_beat(src, {2'(src), 6'(seq[src])}, k == len - 1);
            seq[src]++;
        end
    endtask

    task automatic cycle();
        logic [N-1:0] rdy;
        bit           acc;
        int           src;
        bit           wr_pre;
        bit           stall;
        logic [7:0]   dat;
        bit           lst;
        int           win;
        int           g;
        rdy    = pred_ready();
        acc    = |rdy;
        src    = m_owner;
        wr_pre = m_wr;
        stall  = m_owner >= 0 && bus.req_valid[m_owner] === 1'b1 && !((occ + int'(m_wr)) < DEPTH);
        dat    = acc ? q_data[src][0] : 8'h00;
        lst    = acc ? q_last[src][0] : 1'b0;
        @(posedge clk);
        if (acc) begin
            void'(q_data[src].pop_front());
            void'(q_last[src].pop_front());
            if (!reset_n) void'(exp_q[src].pop_front());
        end
        if (!reset_n) begin
            m_owner = -1; m_last = N - 1; m_beats = 0; m_wr = 0; m_data = 8'h00;
            m_beat_cnt = 0; m_stall_cnt = 0;
        end else begin
            if (wr_pre) m_beat_cnt = (m_beat_cnt + 1) % 65536;
            if (stall && m_stall_cnt < 65535) m_stall_cnt++;
            if (m_owner < 0) begin
                m_wr = 0;
                win  = -1;
                for (int k = 1; k <= N; k++)
                    if (win < 0 && bus.req_valid[(m_last + k) % N] === 1'b1) win = (m_last + k) % N;
                if (win >= 0) begin
                    m_owner = win; m_last = win; m_beats = 0;
                end
            end else begin
                m_wr = acc;
                if (acc) begin
                    m_data = dat;
                    m_beats++;
                    if (lst || m_beats == MAXB) m_owner = -1;
                end
            end
        end
        if (drain && occ > 0) occ--;
        occ = occ + int'(wr_pre);
        #1;
        chk("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(m_wr));
        chk("fifo_data", 32'(bus.fifo_data), 32'(m_data));
        chk("grant_id", 32'(grant_id), 32'(m_last));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        checks++;
        assert (occ <= DEPTH) else begin
            errors++;
            $error("FAIL fifo_overflow: observed=%0d expected<=%0d", occ, DEPTH);
        end
`ifdef UART_ARB_STATS_EN
        chk("beat_cnt", 32'(beat_cnt), 32'(m_beat_cnt));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
`endif
        if (bus.fifo_wr_en === 1'b1) begin
            g = int'(grant_id);
            checks++;
            assert (exp_q[g].size() != 0) else begin
                errors++;
                $error("FAIL sb_extra_write: observed=%0h expected=none", bus.fifo_data);
            end
            if (exp_q[g].size() != 0) chk("sb_order", 32'(bus.fifo_data), 32'(exp_q[g].pop_front()));
        end
        apply_inputs();
        #1;
        chk("req_ready", 32'(bus.req_ready), 32'(pred_ready()));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        apply_inputs();
        cycle();
        reset_n = 1'b1;
        apply_inputs();
    endtask

    initial begin
        bit prev_busy;
        bit all_empty;
        for (int i = 0; i < N; i++) begin
            seq[i] = 0;
            pause[i] = 0;
        end
        m_owner = -1; m_last = N - 1; m_beats = 0; m_wr = 0; m_data = 8'h00;
        m_beat_cnt = 0; m_stall_cnt = 0;
        occ = 0;
        drain = 1;
        bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0;
        bus.fifo_data_count = '0;

        // reset values
        reset_n = 1'b0;
        apply_inputs();
        repeat (2) cycle();
        chk("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        chk("rst_data", 32'(bus.fifo_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'(N - 1));
        reset_n = 1'b1;

        // two-byte message from requester 0
        add_beat(0, 8'h41, 0);
        add_beat(0, 8'h42, 1);
        apply_inputs();
        cycle();
        chk("t1_arb_busy", 32'(busy), 32'd1);
        chk("t1_arb_wr", 32'(bus.fifo_wr_en), 32'd0);
        chk("t1_grant", 32'(grant_id), 32'd0);
        cycle();
        chk("t1_b0_wr", 32'(bus.fifo_wr_en), 32'd1);
        chk("t1_b0_data", 32'(bus.fifo_data), 32'h41);
        cycle();
        chk("t1_b1_data", 32'(bus.fifo_data), 32'h42);
        chk("t1_b1_busy", 32'(busy), 32'd0);
        cycle();
        chk("t1_done_wr", 32'(bus.fifo_wr_en), 32'd0);

        // all four requesters with long messages: strict rotation
        do_reset();
        for (int i = 0; i < N; i++) add_msg(i, 8);
        apply_inputs();
        prev_busy = 1'b0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (busy === 1'b1 && !prev_busy) glog.push_back(int'(grant_id));
            prev_busy = (busy === 1'b1);
        end
        chk("t2_grants", 32'(glog.size() >= 5), 32'd1);
        for (int k = 0; k < 5 && k < glog.size(); k++) chk("t2_rotation", 32'(glog[k]), 32'(exp_rot[k]));
        repeat (30) cycle();

        // FIFO full: no drain until the grant stalls
        drain = 0;
        add_msg(1, 20);
        apply_inputs();
        repeat (40) cycle();
        chk("t3_full_ready", 32'(bus.req_ready), 32'd0);
        chk("t3_full_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 3; k++) begin
            drain = 1;
            cycle();
            drain = 0;
            repeat (3) cycle();
        end
        drain = 1;
        repeat (30) cycle();

        // requester 2 drops valid mid-burst while requester 1 waits
        add_msg(2, 4);
        apply_inputs();
        for (int k = 0; k < 20 && !(busy === 1'b1 && grant_id === 2'd2); k++) cycle();
        chk("t4_granted", 32'(grant_id), 32'd2);
        cycle();
        pause[2] = 1;
        add_msg(1, 3);
        apply_inputs();
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t4_hold_grant", 32'(grant_id), 32'd2);
            if (k > 0) chk("t4_hold_nowr", 32'(bus.fifo_wr_en), 32'd0);
        end
        pause[2] = 0;
        apply_inputs();
        repeat (25) cycle();

        // reset during beat 2 of a burst
        add_msg(0, 4);
        apply_inputs();
        for (int k = 0; k < 20 && !(busy === 1'b1 && grant_id === 2'd0); k++) cycle();
        chk("t5_granted", 32'(grant_id), 32'd0);
        cycle();
        reset_n = 1'b0;
        apply_inputs();
        cycle();
        chk("t5_rst_wr", 32'(bus.fifo_wr_en), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_grant", 32'(grant_id), 32'(N - 1));
        reset_n = 1'b1;
        apply_inputs();
        cycle();
        chk("t5_regrant", 32'(grant_id), 32'd0);
        repeat (20) cycle();

        // random traffic
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                int s;
                s = int'($urandom_range(0, N - 1));
                if (q_data[s].size() < 20) add_msg(s, int'($urandom_range(1, 7)));
            end
            if ($urandom_range(0, 15) == 0) begin
                int p;
                p = int'($urandom_range(0, N - 1));
                pause[p] = !pause[p];
            end
            drain = ($urandom_range(0, 3) != 0);
            apply_inputs();
            cycle();
        end

`ifdef UART_ARB_STATS_EN
        // hold a full FIFO long enough to saturate the stall counter
        for (int i = 0; i < N; i++) pause[i] = 0;
        drain = 0;
        add_msg(3, 40);
        apply_inputs();
        repeat (65600) cycle();
        chk("stat_sat", 32'(stall_cnt), 32'h0000FFFF);
`endif

        // drain everything and confirm complete delivery
        for (int i = 0; i < N; i++) pause[i] = 0;
        drain = 1;
        apply_inputs();
        for (int k = 0; k < 800; k++) begin
            all_empty = 1;
            for (int i = 0; i < N; i++) if (q_data[i].size() != 0) all_empty = 0;
            if (all_empty && m_owner < 0 && !m_wr) break;
            cycle();
        end
        repeat (3) cycle();
        for (int i = 0; i < N; i++) chk("final_undelivered", 32'(exp_q[i].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
